// File: rtl/vector_store_unit_pkg.sv
// Shared types for the vector store path: register/element/DDR widths, FSM states
// and the beat record carried through the skid FIFO.
package vector_store_unit_pkg;

   localparam int unsigned D = 1024;

   typedef logic [2:0]  v_addr_t;
   typedef logic [9:0]  DI_t;
   typedef logic [7:0]  fixed_point_t;
   typedef logic [32:0] ddr_address_t;
   typedef logic [7:0]  ddr_data_t;

   typedef enum logic [1:0] {
      VS_IDLE,
      VS_RUN,
      VS_DRAIN,
      VS_DONE
   } vstore_state_t;

   typedef struct packed {
      ddr_address_t addr;
      fixed_point_t data;
      logic         last;
   } vs_beat_t;

endpackage

// File: rtl/vector_store_unit_skid_fifo.sv
// Small skid FIFO between the VRF read return and the DDR write port. An arriving
// beat is presented at the head in the same cycle when the FIFO is empty.
module store_skid_fifo
   import vector_store_unit_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  vs_beat_t        push_beat_i,
   input  logic            pop_i,
   output logic            valid_o,
   output vs_beat_t        head_o,
   output logic [CntW-1:0] count_o
);

   vs_beat_t        mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            empty, store, take;

   assign empty   = (count_q == '0);
   assign valid_o = !empty || push_i;
   assign head_o  = empty ? push_beat_i : mem_q[rd_ptr_q];
   assign count_o = count_q;

   // A beat that bypasses straight through an empty FIFO is never stored.
   assign store = push_i && !(empty && pop_i);
   assign take  = pop_i && !empty;

   always_comb begin
      count_d = count_q;
      if (store && !take) count_d = count_q + 1'b1;
      else if (take && !store) count_d = count_q - 1'b1;
   end

   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (store) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (take)  rd_ptr_q <= ptr_next(rd_ptr_q);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem_q[wr_ptr_q] <= push_beat_i;
   end

endmodule

// File: rtl/vector_store_unit.sv
// SV op engine: reads every element of one vector register and writes it to DDR,
// one element per beat at ascending addresses from a latched base.
module vector_store_unit
   import vector_store_unit_pkg::*;
#(
   parameter int unsigned D         = vector_store_unit_pkg::D,
   parameter int unsigned FifoDepth = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  v_addr_t      v_src_i,
   input  ddr_address_t ddr_base_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         vrf_ren_o,
   output v_addr_t      vrf_raddr_o,
   output DI_t          vrf_ridx_o,
   input  fixed_point_t vrf_rdata_i,
   output logic         ddr_wvalid_o,
   input  logic         ddr_wready_i,
   output ddr_address_t ddr_waddr_o,
   output fixed_point_t ddr_wdata_o,
   output logic         ddr_wlast_o
);

   localparam int unsigned IdxW = $clog2(D) + 1;
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam int unsigned OccW = CntW + 1;

   vstore_state_t    state_q;
   v_addr_t          src_q;
   ddr_address_t     base_q;
   logic [IdxW-1:0]  rd_idx_q, wr_idx_q;
   logic [IdxW-2:0]  pend_idx_q;
   logic             pend_last_q;
   logic             inflight_q;

   logic             fifo_valid, pop, issue;
   logic [CntW-1:0]  fifo_count;
   vs_beat_t         push_beat, head_beat;

   assign pop = fifo_valid && ddr_wready_i;

   // Room check counts the read already in flight and credits this cycle's pop.
   assign issue = (state_q == VS_RUN) &&
                  ((OccW'(fifo_count) + OccW'(inflight_q)) < (OccW'(FifoDepth) + OccW'(pop)));

   assign push_beat.addr = base_q + ddr_address_t'(pend_idx_q);
   assign push_beat.data = vrf_rdata_i;
   assign push_beat.last = pend_last_q;

   store_skid_fifo #(.Depth(FifoDepth)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_beat_i (push_beat),
      .pop_i       (pop),
      .valid_o     (fifo_valid),
      .head_o      (head_beat),
      .count_o     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= VS_IDLE;
         rd_idx_q   <= '0;
         wr_idx_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) rd_idx_q <= rd_idx_q + 1'b1;
         if (pop)   wr_idx_q <= wr_idx_q + 1'b1;
         unique case (state_q)
            VS_IDLE: begin
               if (start_i) begin
                  rd_idx_q <= '0;
                  wr_idx_q <= '0;
                  state_q  <= VS_RUN;
               end
            end
            VS_RUN: begin
               if (issue && (rd_idx_q == IdxW'(D - 1))) state_q <= VS_DRAIN;
            end
            VS_DRAIN: begin
               if (pop && (wr_idx_q == IdxW'(D - 1))) state_q <= VS_DONE;
            end
            VS_DONE: state_q <= VS_IDLE;
            default: state_q <= VS_IDLE;
         endcase
      end
   end

   // Operand and per-read bookkeeping; qualified by control, so no reset needed.
   always_ff @(posedge clk) begin
      if (state_q == VS_IDLE && start_i) begin
         src_q  <= v_src_i;
         base_q <= ddr_base_i;
      end
      if (issue) begin
         pend_idx_q  <= rd_idx_q[IdxW-2:0];
         pend_last_q <= (rd_idx_q == IdxW'(D - 1));
      end
   end

   assign busy_o       = (state_q == VS_RUN) || (state_q == VS_DRAIN);
   assign done_o       = (state_q == VS_DONE);
   assign vrf_ren_o    = issue;
   assign vrf_raddr_o  = issue ? src_q : '0;
   assign vrf_ridx_o   = issue ? DI_t'(rd_idx_q[IdxW-2:0]) : '0;
   assign ddr_wvalid_o = fifo_valid;
   assign ddr_waddr_o  = fifo_valid ? head_beat.addr : '0;
   assign ddr_wdata_o  = fifo_valid ? head_beat.data : '0;
   assign ddr_wlast_o  = fifo_valid && head_beat.last;

endmodule

// File: tb/tb_vector_store_unit.sv
// Bench for vector_store_unit: VRF memory model, randomized DDR ready, and a
// monitor that checks every read and accepted beat against the expected sequence.
module tb_vector_store_unit;

   localparam int D = 1024;

   logic        clk = 1'b0;
   logic        rst, start_i, ddr_wready_i;
   logic [2:0]  v_src_i, vrf_raddr_o;
   logic [32:0] ddr_base_i, ddr_waddr_o;
   logic [9:0]  vrf_ridx_o;
   logic [7:0]  vrf_rdata_i, ddr_wdata_o;
   logic        busy_o, done_o, vrf_ren_o, ddr_wvalid_o, ddr_wlast_o;

   vector_store_unit dut (
      .clk(clk), .rst(rst), .start_i(start_i), .v_src_i(v_src_i), .ddr_base_i(ddr_base_i),
      .busy_o(busy_o), .done_o(done_o), .vrf_ren_o(vrf_ren_o), .vrf_raddr_o(vrf_raddr_o),
      .vrf_ridx_o(vrf_ridx_o), .vrf_rdata_i(vrf_rdata_i), .ddr_wvalid_o(ddr_wvalid_o),
      .ddr_wready_i(ddr_wready_i), .ddr_waddr_o(ddr_waddr_o), .ddr_wdata_o(ddr_wdata_o),
      .ddr_wlast_o(ddr_wlast_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // VRF: registered read, garbage on cycles without a read enable
   logic [7:0] vrf [8][D];
   always @(posedge clk) vrf_rdata_i <= vrf_ren_o ? vrf[vrf_raddr_o][vrf_ridx_o] : 8'($urandom);

   int n_checks = 0, n_errors = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int ready_mode = 0;
   initial forever begin
      @(posedge clk); #1;
      ddr_wready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // expected-sequence model state
   bit          mon_en = 0, stall_prev = 0;
   int          exp_src, e0, rel, ren_cnt, beat_cnt, done_cnt, saw_stall;
   int          done_rel, first_ren_rel, first_wv_rel;
   logic [32:0] exp_base, held_addr, last_addr;
   logic [7:0]  held_data;
   logic        held_last;
   logic [32:0] first_addr [3];

   always @(negedge clk) begin
      if (mon_en) begin
         rel = cyc - e0 + 1;
         if (vrf_ren_o) begin
            if (ren_cnt == 0) first_ren_rel = rel;
            chk("ren_src", 64'(vrf_raddr_o), 64'(exp_src));
            chk("ren_idx", 64'(vrf_ridx_o), 64'(ren_cnt));
            ren_cnt++;
         end
         if (stall_prev) begin
            chk("hold_valid", 64'(ddr_wvalid_o), 64'(1));
            chk("hold_addr", 64'(ddr_waddr_o), 64'(held_addr));
            chk("hold_data", 64'(ddr_wdata_o), 64'(held_data));
            chk("hold_last", 64'(ddr_wlast_o), 64'(held_last));
         end
         stall_prev = 0;
         if (ddr_wvalid_o) begin
            if (first_wv_rel < 0) first_wv_rel = rel;
            if (ddr_wready_i) begin
               if (beat_cnt >= D) chk("extra_beat", 64'(beat_cnt), 64'(D - 1));
               else begin
                  chk("beat_addr", 64'(ddr_waddr_o), 64'(33'(exp_base + 33'(beat_cnt))));
                  chk("beat_data", 64'(ddr_wdata_o), 64'(vrf[exp_src][beat_cnt]));
                  chk("beat_last", 64'(ddr_wlast_o), 64'(beat_cnt == D - 1));
                  if (beat_cnt < 3) first_addr[beat_cnt] = ddr_waddr_o;
                  last_addr = ddr_waddr_o;
               end
               beat_cnt++;
            end else begin
               saw_stall++;
               stall_prev = 1;
               held_addr  = ddr_waddr_o;
               held_data  = ddr_wdata_o;
               held_last  = ddr_wlast_o;
            end
         end
         if (done_o) begin
            done_cnt++;
            done_rel = rel;
            chk("done_beats", 64'(beat_cnt), 64'(D));
            chk("done_reads", 64'(ren_cnt), 64'(D));
            chk("done_busy", 64'(busy_o), 64'(0));
         end
      end
   end

   task automatic do_start(input logic [2:0] src, input logic [32:0] base);
      mon_en = 0;
      @(posedge clk); #2;
      start_i = 1; v_src_i = src; ddr_base_i = base;
      exp_src = int'(src); exp_base = base;
      ren_cnt = 0; beat_cnt = 0; done_cnt = 0; saw_stall = 0; stall_prev = 0;
      done_rel = -1; first_ren_rel = -1; first_wv_rel = -1;
      @(posedge clk); #2;
      e0 = cyc;
      start_i = 0; v_src_i = 3'($urandom); ddr_base_i = {1'($urandom), 32'($urandom)};
      mon_en = 1;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && done_cnt == 0; i++) @(posedge clk);
      chk("done_seen", 64'(done_cnt), 64'(1));
      repeat (3) @(posedge clk);
      chk("single_done", 64'(done_cnt), 64'(1));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 0);
      chk({tag, "_done"}, 64'(done_o), 0);
      chk({tag, "_ren"}, 64'({vrf_ren_o, vrf_raddr_o, vrf_ridx_o}), 0);
      chk({tag, "_wvalid"}, 64'(ddr_wvalid_o), 0);
      chk({tag, "_payload"}, 64'({ddr_waddr_o, ddr_wdata_o, ddr_wlast_o}), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      int nz;
      logic [32:0] b;
      rst = 1; start_i = 0; v_src_i = 0; ddr_base_i = 0; ddr_wready_i = 0;
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < D; i++) vrf[r][i] = 8'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #2 rst = 0;

      // 1: full store, ready always high, latency pinned by hand
      ready_mode = 0;
      do_start(3'd3, 33'h1_0000_0000);
      wait_done(3000);
      chk("t1_first_ren_cycle", 64'(first_ren_rel), 1);
      chk("t1_first_wvalid_cycle", 64'(first_wv_rel), 2);
      chk("t1_done_cycle", 64'(done_rel), 1026);
      chk("t1_first_addr", 64'(first_addr[0]), 64'h1_0000_0000);
      chk("t1_last_addr", 64'(last_addr), 64'h1_0000_03FF);

      // 2: random backpressure
      ready_mode = 1;
      do_start(3'd6, {1'($urandom), 32'($urandom)});
      wait_done(8000);
      chk("t2_saw_stall", 64'(saw_stall > 0), 1);

      // 3: address wrap at 2^33
      ready_mode = 0;
      do_start(3'd1, 33'h1_FFFF_FFFE);
      wait_done(3000);
      chk("t3_addr0", 64'(first_addr[0]), 64'h1_FFFF_FFFE);
      chk("t3_addr1", 64'(first_addr[1]), 64'h1_FFFF_FFFF);
      chk("t3_addr2", 64'(first_addr[2]), 64'h0_0000_0000);

      // 4: ready held low for 20 cycles
      ready_mode = 2;
      b = {1'($urandom), 32'($urandom)};
      do_start(3'd2, b);
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      chk("t4_ren_pulses", 64'(ren_cnt), 2);
      chk("t4_wvalid_held", 64'(ddr_wvalid_o), 1);
      chk("t4_waddr_idx0", 64'(ddr_waddr_o), 64'(b));
      chk("t4_wdata_idx0", 64'(ddr_wdata_o), 64'(vrf[2][0]));
      ready_mode = 1;
      wait_done(8000);

      // 5: start while busy and in the DONE cycle are ignored
      ready_mode = 0;
      do_start(3'd3, 33'h0_1234_5000);
      repeat (9) @(posedge clk);
      #2 start_i = 1; v_src_i = 3'd5; ddr_base_i = 33'h0;
      @(posedge clk); #2 start_i = 0;
      for (int i = 0; i < 3000 && beat_cnt < D; i++) @(posedge clk);
      #2 start_i = 1; v_src_i = 3'd5;
      @(posedge clk); #2 start_i = 0;
      wait_done(10);
      @(negedge clk);
      chk("t5_idle_after_done", 64'({busy_o, vrf_ren_o, ddr_wvalid_o}), 0);

      // 6: reset mid-store aborts; reset wins over start; then a clean store
      ready_mode = 0;
      do_start(3'd4, 33'h0_8000_0000);
      for (int i = 0; i < 3000 && beat_cnt < 500; i++) @(posedge clk);
      chk("t6_reached_500", 64'(beat_cnt >= 500), 1);
      #2 rst = 1; mon_en = 0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("t6_abort");
      @(posedge clk); #2 rst = 0;
      nz = 0;
      repeat (8) begin
         @(negedge clk);
         nz += int'(done_o) + int'(ddr_wvalid_o) + int'(busy_o) + int'(vrf_ren_o);
      end
      chk("t6_quiet_after_abort", 64'(nz), 0);
      @(posedge clk); #2 rst = 1; start_i = 1; v_src_i = 3'd1;
      @(posedge clk); #2 rst = 0; start_i = 0;
      @(negedge clk);
      chk("t6_start_with_rst", 64'(busy_o), 0);
      ready_mode = 1;
      do_start(3'd7, {1'($urandom), 32'($urandom)});
      wait_done(8000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
